// File: rtl/bw_seq_pkg.sv
// Shared encodings and defaults for the PCIe bandwidth test sequencer.
package bw_seq_pkg;

  localparam int ITER_W_DEF = 16;
  localparam int SUM_W_DEF  = 48;
  localparam int TIME_W     = 32;

  localparam logic [1:0] MODE_W       = 2'd0;
  localparam logic [1:0] MODE_R       = 2'd1;
  localparam logic [1:0] MODE_WR_SEQ  = 2'd2;
  localparam logic [1:0] MODE_WR_CONC = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_RISE,
    ST_WAIT_FALL,
    ST_NEXT_PHASE,
    ST_FINISH
  } seq_state_t;

endpackage

// File: rtl/bw_test_sequencer_engine_tracker.sv
// Per-engine rise/fall tracking and saturating time accumulation.
// Optional min/max run-time capture when BW_SEQ_MINMAX_EN is defined.
module engine_tracker
  import bw_seq_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              arm,
  input  logic              disarm,
  input  logic              busy,
  input  logic [TIME_W-1:0] run_time,
  output logic              seen,
  output logic              idle,
  output logic [SUM_W-1:0]  sum
`ifdef BW_SEQ_MINMAX_EN
  ,
  output logic [TIME_W-1:0] min_time,
  output logic [TIME_W-1:0] max_time
`endif
);

  logic             seen_reg;
  logic             pending_reg;
  logic [SUM_W-1:0] sum_reg;
  logic             fall;
  logic [SUM_W:0]   sum_wide;

  // A run ends on the first low busy after the rise was seen, even if the pulse was short.
  assign fall     = pending_reg && seen_reg && !busy;
  assign sum_wide = {1'b0, sum_reg} + (SUM_W + 1)'(run_time);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seen_reg    <= 1'b0;
      pending_reg <= 1'b0;
      sum_reg     <= '0;
    end else begin
      if (clear || disarm) begin
        seen_reg    <= 1'b0;
        pending_reg <= 1'b0;
      end else if (arm) begin
        seen_reg    <= busy;
        pending_reg <= 1'b1;
      end else if (pending_reg) begin
        if (busy) seen_reg <= 1'b1;
        if (fall) pending_reg <= 1'b0;
      end
      if (clear) sum_reg <= '0;
      else if (fall) sum_reg <= sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
    end
  end

  assign seen = seen_reg;
  assign idle = !pending_reg || fall;
  assign sum  = sum_reg;

`ifdef BW_SEQ_MINMAX_EN
  logic [TIME_W-1:0] min_reg;
  logic [TIME_W-1:0] max_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_reg <= '0;
      max_reg <= '0;
    end else if (clear) begin
      min_reg <= '1;
      max_reg <= '0;
    end else if (fall) begin
      if (run_time < min_reg) min_reg <= run_time;
      if (run_time > max_reg) max_reg <= run_time;
    end
  end

  assign min_time = min_reg;
  assign max_time = max_reg;
`endif

endmodule

// File: rtl/bw_test_sequencer.sv
// Sequences write/read DMA bandwidth engines on two channels and accumulates run times.
// Define BW_SEQ_MINMAX_EN to add per-engine min/max run-time outputs.
module bw_test_sequencer
  import bw_seq_pkg::*;
#(
  parameter int ITER_W       = ITER_W_DEF,
  parameter int SUM_W        = SUM_W_DEF,
  parameter int RISE_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [1:0]        cmd_mode,
  input  logic [1:0]        cmd_chan_mask,
  input  logic [ITER_W-1:0] cmd_iterations,
  output logic              start_write_0,
  output logic              start_write_1,
  output logic              start_read_0,
  output logic              start_read_1,
  input  logic              write_busy_0,
  input  logic              write_busy_1,
  input  logic              read_busy_0,
  input  logic              read_busy_1,
  input  logic [31:0]       write_time_0,
  input  logic [31:0]       write_time_1,
  input  logic [31:0]       read_time_0,
  input  logic [31:0]       read_time_1,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_error,
  output logic [ITER_W-1:0] iter_count,
  output logic [SUM_W-1:0]  wsum_0,
  output logic [SUM_W-1:0]  wsum_1,
  output logic [SUM_W-1:0]  rsum_0,
  output logic [SUM_W-1:0]  rsum_1
`ifdef BW_SEQ_MINMAX_EN
  ,
  output logic [31:0]       wmin_0,
  output logic [31:0]       wmax_0,
  output logic [31:0]       wmin_1,
  output logic [31:0]       wmax_1,
  output logic [31:0]       rmin_0,
  output logic [31:0]       rmax_0,
  output logic [31:0]       rmin_1,
  output logic [31:0]       rmax_1
`endif
);

  localparam int TMR_W = $clog2(RISE_TIMEOUT + 1);

  seq_state_t        state_reg, state_next;
  logic [1:0]        mode_reg;
  logic [1:0]        mask_reg;
  logic [ITER_W-1:0] target_reg;
  logic [ITER_W-1:0] iter_reg;
  logic              phase_rd_reg;
  logic              abort_reg;
  logic              error_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [3:0]        launched_reg;

  logic              accept, wr_phase, rd_phase, all_seen, all_idle, timeout, last_iter;
  logic [ITER_W-1:0] iter_inc;
  logic [3:0]        arm, busy_vec, seen_vec, idle_vec;
  logic [31:0]       time_vec [4];
  logic [SUM_W-1:0]  sum_vec [4];

  // Engine index order: 0=write ch0, 1=write ch1, 2=read ch0, 3=read ch1.
  assign busy_vec    = {read_busy_1, read_busy_0, write_busy_1, write_busy_0};
  assign time_vec[0] = write_time_0;
  assign time_vec[1] = write_time_1;
  assign time_vec[2] = read_time_0;
  assign time_vec[3] = read_time_1;

  assign accept   = (state_reg == ST_IDLE) && cmd_start;
  assign wr_phase = (mode_reg == MODE_W) || (mode_reg == MODE_WR_CONC) ||
                    ((mode_reg == MODE_WR_SEQ) && !phase_rd_reg);
  assign rd_phase = (mode_reg == MODE_R) || (mode_reg == MODE_WR_CONC) ||
                    ((mode_reg == MODE_WR_SEQ) && phase_rd_reg);
  assign arm      = (state_reg == ST_LAUNCH) ?
                    {mask_reg & {2{rd_phase}}, mask_reg & {2{wr_phase}}} : 4'b0000;
  assign all_seen = &(seen_vec | busy_vec | ~launched_reg);
  assign all_idle = &(idle_vec | ~launched_reg);
  assign timeout  = (timer_reg == TMR_W'(RISE_TIMEOUT - 1));
  assign iter_inc = (iter_reg == target_reg) ? iter_reg : iter_reg + ITER_W'(1);
  assign last_iter = (iter_inc == target_reg) || abort_reg || cmd_abort;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (cmd_start) state_next = (cmd_chan_mask == 2'b00) ? ST_FINISH : ST_LAUNCH;
      ST_LAUNCH:     state_next = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (all_seen) state_next = ST_WAIT_FALL;
        else if (timeout) state_next = ST_FINISH;
      end
      ST_WAIT_FALL:  if (all_idle) state_next = ST_NEXT_PHASE;
      ST_NEXT_PHASE: begin
        if ((mode_reg == MODE_WR_SEQ) && !phase_rd_reg) state_next = ST_LAUNCH;
        else state_next = last_iter ? ST_FINISH : ST_LAUNCH;
      end
      ST_FINISH:     state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= MODE_W;
      mask_reg     <= 2'b00;
      target_reg   <= '0;
      iter_reg     <= '0;
      phase_rd_reg <= 1'b0;
      abort_reg    <= 1'b0;
      error_reg    <= 1'b0;
      timer_reg    <= '0;
      launched_reg <= 4'b0000;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mode_reg     <= cmd_mode;
        mask_reg     <= cmd_chan_mask;
        target_reg   <= (cmd_iterations == '0) ? ITER_W'(1) : cmd_iterations;
        iter_reg     <= '0;
        phase_rd_reg <= 1'b0;
        abort_reg    <= 1'b0;
        error_reg    <= 1'b0;
      end else if (state_reg == ST_FINISH) begin
        abort_reg <= 1'b0;
      end else if ((state_reg != ST_IDLE) && cmd_abort) begin
        abort_reg <= 1'b1;
      end
      if (state_reg == ST_LAUNCH) begin
        launched_reg <= arm;
        timer_reg    <= '0;
      end else if ((state_reg == ST_WAIT_RISE) && !all_seen) begin
        timer_reg <= timer_reg + TMR_W'(1);
        if (timeout) error_reg <= 1'b1;
      end
      if (state_reg == ST_NEXT_PHASE) begin
        if ((mode_reg == MODE_WR_SEQ) && !phase_rd_reg) begin
          phase_rd_reg <= 1'b1;
        end else begin
          iter_reg     <= iter_inc;
          phase_rd_reg <= 1'b0;
        end
      end
    end
  end

`ifdef BW_SEQ_MINMAX_EN
  logic [31:0] min_vec [4];
  logic [31:0] max_vec [4];
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_trk
    engine_tracker #(.SUM_W(SUM_W)) u_trk (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (accept),
      .arm      (arm[gi]),
      .disarm   (state_reg == ST_FINISH),
      .busy     (busy_vec[gi]),
      .run_time (time_vec[gi]),
      .seen     (seen_vec[gi]),
      .idle     (idle_vec[gi]),
      .sum      (sum_vec[gi])
`ifdef BW_SEQ_MINMAX_EN
      ,
      .min_time (min_vec[gi]),
      .max_time (max_vec[gi])
`endif
    );
  end

  assign {start_read_1, start_read_0, start_write_1, start_write_0} = arm;
  assign seq_busy   = (state_reg != ST_IDLE);
  assign seq_done   = (state_reg == ST_FINISH);
  assign seq_error  = error_reg;
  assign iter_count = iter_reg;
  assign wsum_0     = sum_vec[0];
  assign wsum_1     = sum_vec[1];
  assign rsum_0     = sum_vec[2];
  assign rsum_1     = sum_vec[3];

`ifdef BW_SEQ_MINMAX_EN
  assign wmin_0 = min_vec[0];
  assign wmax_0 = max_vec[0];
  assign wmin_1 = min_vec[1];
  assign wmax_1 = max_vec[1];
  assign rmin_0 = min_vec[2];
  assign rmax_0 = max_vec[2];
  assign rmin_1 = min_vec[3];
  assign rmax_1 = max_vec[3];
`endif

endmodule

// File: tb/tb_bw_test_sequencer.sv
// Scoreboard bench for bw_test_sequencer with behavioural engine models.
module tb_bw_test_sequencer;

  localparam int RT = 64;
  localparam int SW = 33;
  localparam int IW = 16;

  typedef struct packed {
    logic [IW-1:0] iter;
    logic [SW-1:0] ws0;
    logic [SW-1:0] ws1;
    logic [SW-1:0] rs0;
    logic [SW-1:0] rs1;
    logic          err;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, cmd_start, cmd_abort;
  logic [1:0]    cmd_mode, cmd_chan_mask;
  logic [IW-1:0] cmd_iterations;
  logic          start_write_0, start_write_1, start_read_0, start_read_1;
  logic          seq_busy, seq_done, seq_error;
  logic [IW-1:0] iter_count;
  logic [SW-1:0] wsum_0, wsum_1, rsum_0, rsum_1;
`ifdef BW_SEQ_MINMAX_EN
  logic [31:0]   wmin_0, wmax_0, wmin_1, wmax_1, rmin_0, rmax_0, rmin_1, rmax_1;
`endif

  // Engine models: index 0=W0, 1=W1, 2=R0, 3=R1
  logic [3:0]  eng_busy = 4'b0000;
  logic [31:0] eng_time [4] = '{default: 32'd0};
  int          remain [4] = '{default: 0};
  int          start_cnt [4] = '{default: 0};
  bit          respond [4];
  int          run_len [4];
  logic [31:0] run_val [4];
  logic [3:0]  starts;
  int          done_cnt = 0;
  int          viol_cnt = 0;

  res_t exp_q[$];
  res_t obs, e;
  int   n_checks = 0;
  int   n_fail = 0;

  assign starts = {start_read_1, start_read_0, start_write_1, start_write_0};

  bw_test_sequencer #(.ITER_W(IW), .SUM_W(SW), .RISE_TIMEOUT(RT)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .cmd_start      (cmd_start),
    .cmd_abort      (cmd_abort),
    .cmd_mode       (cmd_mode),
    .cmd_chan_mask  (cmd_chan_mask),
    .cmd_iterations (cmd_iterations),
    .start_write_0  (start_write_0),
    .start_write_1  (start_write_1),
    .start_read_0   (start_read_0),
    .start_read_1   (start_read_1),
    .write_busy_0   (eng_busy[0]),
    .write_busy_1   (eng_busy[1]),
    .read_busy_0    (eng_busy[2]),
    .read_busy_1    (eng_busy[3]),
    .write_time_0   (eng_time[0]),
    .write_time_1   (eng_time[1]),
    .read_time_0    (eng_time[2]),
    .read_time_1    (eng_time[3]),
    .seq_busy       (seq_busy),
    .seq_done       (seq_done),
    .seq_error      (seq_error),
    .iter_count     (iter_count),
    .wsum_0         (wsum_0),
    .wsum_1         (wsum_1),
    .rsum_0         (rsum_0),
    .rsum_1         (rsum_1)
`ifdef BW_SEQ_MINMAX_EN
    ,
    .wmin_0 (wmin_0), .wmax_0 (wmax_0), .wmin_1 (wmin_1), .wmax_1 (wmax_1),
    .rmin_0 (rmin_0), .rmax_0 (rmax_0), .rmin_1 (rmin_1), .rmax_1 (rmax_1)
`endif
  );

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (starts[k]) begin
        start_cnt[k] <= start_cnt[k] + 1;
        if (respond[k]) begin
          eng_busy[k] <= 1'b1;
          remain[k]   <= run_len[k] - 1;
          eng_time[k] <= run_val[k];
        end
      end else if (eng_busy[k]) begin
        if (remain[k] == 0) eng_busy[k] <= 1'b0;
        else remain[k] <= remain[k] - 1;
      end
    end
    if ((start_read_0 || start_read_1) && (eng_busy[0] || eng_busy[1])) viol_cnt <= viol_cnt + 1;
  end

  always @(negedge clk) if (seq_done) done_cnt <= done_cnt + 1;

  task automatic set_eng(input int k, input bit r, input int len, input logic [31:0] v);
    respond[k] = r;
    run_len[k] = len;
    run_val[k] = v;
  endtask

  task automatic issue(input logic [1:0] m, input logic [1:0] k, input logic [IW-1:0] n);
    @(negedge clk);
    cmd_mode = m; cmd_chan_mask = k; cmd_iterations = n; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int dcyc, output int fcyc);
    logic [3:0] prev;
    prev = eng_busy; ok = 1'b0; dcyc = -1; fcyc = -1;
    for (int i = 1; i <= budget && !ok; i++) begin
      @(negedge clk);
      if ((prev & ~eng_busy) != 4'b0000) fcyc = i;
      prev = eng_busy;
      if (seq_done) begin ok = 1'b1; dcyc = i; end
    end
  endtask

  task automatic snap_obs();
    obs = {iter_count, wsum_0, wsum_1, rsum_0, rsum_1, seq_error};
    $display("txn iter=%0d ws0=%0h ws1=%0h rs0=%0h rs1=%0h err=%0b",
             iter_count, wsum_0, wsum_1, rsum_0, rsum_1, seq_error);
  endtask

  task automatic test_reset();
    logic [7+IW+4*SW-1:0] all_out;
    resetn = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0;
    cmd_mode = 2'd0; cmd_chan_mask = 2'd0; cmd_iterations = '0;
    for (int k = 0; k < 4; k++) set_eng(k, 1'b0, 1, 32'd0);
    repeat (3) @(negedge clk);
    all_out = {starts, seq_busy, seq_done, seq_error, iter_count, wsum_0, wsum_1, rsum_0, rsum_1};
    n_checks++;
    if (all_out !== '0) begin
      $display("FAIL reset_outputs: got %h required 0", all_out); n_fail++;
    end
    resetn = 1'b1;
  endtask

  task automatic test_mode0();
    int s[4]; int d0, dcyc, fcyc; bit ok;
    for (int k = 0; k < 4; k++) s[k] = start_cnt[k];
    d0 = done_cnt;
    set_eng(0, 1'b1, 10, 32'd100);
    exp_q.push_back('{iter: 3, ws0: 300, ws1: 0, rs0: 0, rs1: 0, err: 0});
    issue(2'd0, 2'b01, 16'd3);
    repeat (3) @(negedge clk);
    n_checks++;
    if (seq_busy !== 1'b1) begin $display("FAIL mode0_busy: got %b required 1", seq_busy); n_fail++; end
    cmd_mode = 2'd3; cmd_chan_mask = 2'b11; cmd_iterations = 16'd9; cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    wait_done(500, ok, dcyc, fcyc);
    n_checks++;
    if (!ok) begin $display("FAIL mode0_timeout: got no seq_done required seq_done"); n_fail++; end
    snap_obs(); e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL mode0_result: got %h required %h", obs, e); n_fail++; end
    n_checks++;
    if (fcyc < 0 || dcyc - fcyc != 2) begin
      $display("FAIL mode0_latency: got %0d required 2", dcyc - fcyc); n_fail++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({start_cnt[0] - s[0], start_cnt[1] - s[1], start_cnt[2] - s[2], start_cnt[3] - s[3]} !== {32'd3, 32'd0, 32'd0, 32'd0}) begin
      $display("FAIL mode0_starts: got %0d/%0d/%0d/%0d required 3/0/0/0",
               start_cnt[0] - s[0], start_cnt[1] - s[1], start_cnt[2] - s[2], start_cnt[3] - s[3]);
      n_fail++;
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin $display("FAIL mode0_done_count: got %0d required 1", done_cnt - d0); n_fail++; end
    n_checks++;
    if (seq_busy !== 1'b0) begin $display("FAIL mode0_idle: got %b required 0", seq_busy); n_fail++; end
  endtask

  task automatic test_mode2_seq();
    int s[4]; int v0, dcyc, fcyc; bit ok;
    for (int k = 0; k < 4; k++) s[k] = start_cnt[k];
    v0 = viol_cnt;
    set_eng(0, 1'b1, 6, 32'd50); set_eng(1, 1'b1, 9, 32'd60);
    set_eng(2, 1'b1, 5, 32'd70); set_eng(3, 1'b1, 7, 32'd80);
    exp_q.push_back('{iter: 1, ws0: 50, ws1: 60, rs0: 70, rs1: 80, err: 0});
    issue(2'd2, 2'b11, 16'd1);
    wait_done(500, ok, dcyc, fcyc);
    n_checks++;
    if (!ok) begin $display("FAIL mode2_timeout: got no seq_done required seq_done"); n_fail++; end
    snap_obs(); e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL mode2_result: got %h required %h", obs, e); n_fail++; end
    n_checks++;
    if (viol_cnt != v0) begin $display("FAIL mode2_order: got %0d overlaps required 0", viol_cnt - v0); n_fail++; end
    n_checks++;
    if (start_cnt[2] - s[2] != 1 || start_cnt[3] - s[3] != 1 || start_cnt[0] - s[0] != 1) begin
      $display("FAIL mode2_starts: got w0=%0d r0=%0d r1=%0d required 1 each",
               start_cnt[0] - s[0], start_cnt[2] - s[2], start_cnt[3] - s[3]);
      n_fail++;
    end
  endtask

  task automatic test_mode3_conc();
    int dcyc, fcyc; bit ok;
    set_eng(0, 1'b1, 4, 32'd11); set_eng(1, 1'b1, 4, 32'd22);
    set_eng(2, 1'b1, 4, 32'd33); set_eng(3, 1'b1, 4, 32'd44);
    exp_q.push_back('{iter: 1, ws0: 11, ws1: 22, rs0: 33, rs1: 44, err: 0});
    issue(2'd3, 2'b11, 16'd0);
    wait_done(200, ok, dcyc, fcyc);
    n_checks++;
    if (!ok) begin $display("FAIL mode3_timeout: got no seq_done required seq_done"); n_fail++; end
    snap_obs(); e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL mode3_result: got %h required %h", obs, e); n_fail++; end
  endtask

  task automatic test_rise_timeout();
    int s[4]; int errc, dcyc;
    for (int k = 0; k < 4; k++) begin s[k] = start_cnt[k]; set_eng(k, 1'b0, 1, 32'd0); end
    exp_q.push_back('{iter: 0, ws0: 0, ws1: 0, rs0: 0, rs1: 0, err: 1});
    issue(2'd3, 2'b10, 16'd2);
    errc = -1; dcyc = -1;
    for (int i = 1; i <= RT + 20 && dcyc < 0; i++) begin
      @(negedge clk);
      if (seq_error && errc < 0) errc = i;
      if (seq_done) dcyc = i;
    end
    n_checks++;
    if (errc != RT + 1) begin $display("FAIL timeout_error_cycle: got %0d required %0d", errc, RT + 1); n_fail++; end
    n_checks++;
    if (dcyc != RT + 1) begin $display("FAIL timeout_done_cycle: got %0d required %0d", dcyc, RT + 1); n_fail++; end
    snap_obs(); e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL timeout_result: got %h required %h", obs, e); n_fail++; end
    repeat (3) @(negedge clk);
    n_checks++;
    if (seq_error !== 1'b1 || seq_busy !== 1'b0) begin
      $display("FAIL timeout_sticky: got err=%b busy=%b required err=1 busy=0", seq_error, seq_busy); n_fail++;
    end
    n_checks++;
    if (start_cnt[1] - s[1] != 1 || start_cnt[3] - s[3] != 1 || start_cnt[0] != s[0] || start_cnt[2] != s[2]) begin
      $display("FAIL timeout_starts: got w1=%0d r1=%0d w0=%0d r0=%0d required 1/1/0/0",
               start_cnt[1] - s[1], start_cnt[3] - s[3], start_cnt[0] - s[0], start_cnt[2] - s[2]);
      n_fail++;
    end
  endtask

  task automatic test_abort();
    int s0, dcyc, fcyc; bit ok;
    set_eng(0, 1'b1, 10, 32'd7);
    @(negedge clk); cmd_abort = 1'b1; @(negedge clk); cmd_abort = 1'b0;
    s0 = start_cnt[0];
    exp_q.push_back('{iter: 2, ws0: 14, ws1: 0, rs0: 0, rs1: 0, err: 0});
    issue(2'd0, 2'b01, 16'd5);
    for (int i = 0; i < 200 && !(start_cnt[0] - s0 == 2 && eng_busy[0]); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    cmd_abort = 1'b1; @(negedge clk); cmd_abort = 1'b0;
    wait_done(300, ok, dcyc, fcyc);
    n_checks++;
    if (!ok) begin $display("FAIL abort_timeout: got no seq_done required seq_done"); n_fail++; end
    snap_obs(); e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL abort_result: got %h required %h", obs, e); n_fail++; end
    n_checks++;
    if (start_cnt[0] - s0 != 2) begin $display("FAIL abort_starts: got %0d required 2", start_cnt[0] - s0); n_fail++; end
  endtask

  task automatic test_saturate();
    logic [SW+1:0] raw; logic [SW-1:0] sat; int dcyc, fcyc; bit ok;
    raw = 3 * {2'b00, 1'b0, 32'hFFFF_FFFF};
    sat = (raw > {2'b00, {SW{1'b1}}}) ? {SW{1'b1}} : raw[SW-1:0];
    set_eng(0, 1'b1, 3, 32'hFFFF_FFFF);
    exp_q.push_back('{iter: 3, ws0: sat, ws1: 0, rs0: 0, rs1: 0, err: 0});
    issue(2'd0, 2'b01, 16'd3);
    wait_done(300, ok, dcyc, fcyc);
    n_checks++;
    if (!ok) begin $display("FAIL sat_timeout: got no seq_done required seq_done"); n_fail++; end
    snap_obs(); e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL sat_result: got %h required %h", obs, e); n_fail++; end
  endtask

  task automatic test_mask_zero();
    exp_q.push_back('{iter: 0, ws0: 0, ws1: 0, rs0: 0, rs1: 0, err: 0});
    issue(2'd2, 2'b00, 16'd4);
    n_checks++;
    if (seq_done !== 1'b1 || starts !== 4'b0000) begin
      $display("FAIL mask0_done: got done=%b starts=%b required done=1 starts=0000", seq_done, starts); n_fail++;
    end
    snap_obs(); e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL mask0_result: got %h required %h", obs, e); n_fail++; end
    @(negedge clk);
    n_checks++;
    if (seq_done !== 1'b0 || seq_busy !== 1'b0) begin
      $display("FAIL mask0_idle: got done=%b busy=%b required 0/0", seq_done, seq_busy); n_fail++;
    end
  endtask

  task automatic test_reset_midrun();
    logic [7+IW+4*SW-1:0] all_out; int s0, dcyc, fcyc; bit ok;
    set_eng(0, 1'b1, 6, 32'd5);
    s0 = start_cnt[0];
    issue(2'd0, 2'b01, 16'd3);
    for (int i = 0; i < 200 && !(start_cnt[0] - s0 == 2 && eng_busy[0]); i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (wsum_0 !== 33'd5 || seq_busy !== 1'b1) begin
      $display("FAIL rstmid_pre: got ws0=%0d busy=%b required 5/1", wsum_0, seq_busy); n_fail++;
    end
    resetn = 1'b0; #1;
    all_out = {starts, seq_busy, seq_done, seq_error, iter_count, wsum_0, wsum_1, rsum_0, rsum_1};
    n_checks++;
    if (all_out !== '0) begin $display("FAIL rstmid_zero: got %h required 0", all_out); n_fail++; end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 50 && eng_busy != 4'b0000; i++) @(negedge clk);
    exp_q.push_back('{iter: 1, ws0: 5, ws1: 0, rs0: 0, rs1: 0, err: 0});
    issue(2'd0, 2'b01, 16'd1);
    wait_done(200, ok, dcyc, fcyc);
    n_checks++;
    if (!ok) begin $display("FAIL rstmid_timeout: got no seq_done required seq_done"); n_fail++; end
    snap_obs(); e = exp_q.pop_front();
    n_checks++;
    if (obs !== e) begin $display("FAIL rstmid_result: got %h required %h", obs, e); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode2_seq();
    test_mode3_conc();
    test_rise_timeout();
    test_abort();
    test_saturate();
    test_mask_zero();
    test_reset_midrun();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
